// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port synchronous word memory between the
// instruction-fetch path and the load/store path. Data requests win unless
// they have already been granted MAX_DATA_STREAK times in a row while fetch
// waited. The block also aligns store data into byte lanes, extracts and
// extends load data, and flags misaligned or illegal data accesses.
module mem_arbiter #(
  parameter int ADDR_WIDTH      = 32,
  parameter int MAX_DATA_STREAK = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  // fetch port
  input  logic                  if_req_valid,
  output logic                  if_req_ready,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  output logic                  if_rsp_valid,
  output logic [31:0]           if_rdata,
  // load/store port
  input  logic                  d_req_valid,
  output logic                  d_req_ready,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic                  d_we,
  input  logic [1:0]            d_size,
  input  logic                  d_unsigned,
  input  logic [31:0]           d_wdata,
  output logic                  d_rsp_valid,
  output logic [31:0]           d_rdata,
  output logic                  d_err,
  // memory port
  output logic                  mem_en,
  output logic [3:0]            mem_we,
  output logic [ADDR_WIDTH-3:0] mem_addr,
  output logic [31:0]           mem_wdata,
  input  logic [31:0]           mem_rdata
);

  localparam int STREAK_W = $clog2(MAX_DATA_STREAK + 1);

  typedef enum logic [1:0] {
    OWN_NONE  = 2'd0,
    OWN_FETCH = 2'd1,
    OWN_DATA  = 2'd2
  } owner_e;

  // Everything needed to shape the response one cycle after a grant.
  typedef struct packed {
    owner_e     owner;
    logic       we;
    logic [1:0] size;
    logic       is_unsigned;
    logic [1:0] offset;
    logic       err;
  } inflight_t;

  logic                grant_f;
  logic                grant_d;
  logic                misaligned;
  logic [STREAK_W-1:0] streak_q;
  inflight_t           inflight_d;
  inflight_t           inflight_q;
  logic                rsp_f;
  logic                rsp_d;
  logic [31:0]         shifted;
  logic [31:0]         load_data;

  // Fetch address bits [1:0] are word-offset noise and deliberately ignored.
  logic unused_if_lsbs;
  assign unused_if_lsbs = ^if_addr[1:0];

  // Arbitration: data first, fetch forced through once the data streak is full.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    grant_d = 1'b0;
    grant_f = 1'b0;
    if (!rst) begin
      if (d_req_valid && !(if_req_valid && streak_q == STREAK_W'(MAX_DATA_STREAK)))
        grant_d = 1'b1;
      else if (if_req_valid)
        grant_f = 1'b1;
    end
  end

  assign if_req_ready = grant_f;
  assign d_req_ready  = grant_d;

  // Illegal size, odd halfword or non-word-aligned word access.
  always_comb begin
    misaligned = 1'b0;
    unique case (d_size)
      2'b00:   misaligned = 1'b0;
      2'b01:   misaligned = d_addr[0];
      2'b10:   misaligned = (d_addr[1:0] != 2'b00);
      default: misaligned = 1'b1;
    endcase
  end

  // Memory command for this cycle's grant, with store data replicated to lanes.
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 4'b0000;
    mem_addr  = '0;
    mem_wdata = '0;
    if (grant_f) begin
      mem_en   = 1'b1;
      mem_addr = if_addr[ADDR_WIDTH-1:2];
    end else if (grant_d && !misaligned) begin
      mem_en   = 1'b1;
      mem_addr = d_addr[ADDR_WIDTH-1:2];
      if (d_we) begin
        unique case (d_size)
          2'b00: begin
            mem_we    = 4'b0001 << d_addr[1:0];
            mem_wdata = {4{d_wdata[7:0]}};
          end
          2'b01: begin
            mem_we    = 4'b0011 << d_addr[1:0];
            mem_wdata = {2{d_wdata[15:0]}};
          end
          default: begin
            mem_we    = 4'b1111;
            mem_wdata = d_wdata;
          end
        endcase
      end
    end
  end

  // Consecutive data grants while fetch waits; any pause in fetch demand resets it.
  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (rst)
      streak_q <= '0;
    else if (!if_req_valid || grant_f)
      streak_q <= '0;
    else if (grant_d)
      streak_q <= streak_q + STREAK_W'(1);
  end

  // Snapshot of the granted request, consumed by the response logic next cycle.
  always_comb begin
    inflight_d = '0;
    if (grant_f) begin
      inflight_d.owner = OWN_FETCH;
    end else if (grant_d) begin
      inflight_d.owner       = OWN_DATA;
      inflight_d.we          = d_we;
      inflight_d.size        = d_size;
      inflight_d.is_unsigned = d_unsigned;
      inflight_d.offset      = d_addr[1:0];
      inflight_d.err         = misaligned;
    end
  end

  // In-flight register; cleared by reset so no response survives it.
  always_ff @(posedge clk) begin
    if (rst)
      inflight_q <= '0;
    else
      inflight_q <= inflight_d;
  end

  // A response registered just before reset rose must not appear while rst is high.
  assign rsp_f = (inflight_q.owner == OWN_FETCH) && !rst;
  assign rsp_d = (inflight_q.owner == OWN_DATA) && !rst;

  // Load extraction: shift the addressed lane down, then truncate and extend.
  always_comb begin
    shifted   = mem_rdata >> {inflight_q.offset, 3'b000};
    load_data = mem_rdata;
    unique case (inflight_q.size)
      2'b00:   load_data = inflight_q.is_unsigned ? {24'd0, shifted[7:0]}
                                                  : {{24{shifted[7]}}, shifted[7:0]};
      2'b01:   load_data = inflight_q.is_unsigned ? {16'd0, shifted[15:0]}
                                                  : {{16{shifted[15]}}, shifted[15:0]};
      default: load_data = mem_rdata;
    endcase
  end

  assign if_rsp_valid = rsp_f;
  assign if_rdata     = rsp_f ? mem_rdata : 32'd0;
  assign d_rsp_valid  = rsp_d;
  assign d_err        = rsp_d && inflight_q.err;
  assign d_rdata      = (rsp_d && !inflight_q.we && !inflight_q.err) ? load_data : 32'd0;

endmodule
